unified_mem_arbiter: RTL and testbench

Shares the single-ported unified instruction/data memory between the fetch path and the load/store path. It also sequences each multi-cycle memory access through a small FSM and converts store width codes into byte enables and lane-replicated write data. It drives stall signals back to the datapath and sits between the control/datapath and the memory model.

---
 rtl/unified_mem_arbiter_pkg.sv | 18 +
 rtl/unified_mem_arbiter_store_lane_gen.sv | 36 +++
 rtl/unified_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: store width codes and arbiter FSM states.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SM_BYTE = 2'b00,
    SM_HALF = 2'b01,
    SM_WORD = 2'b10,
    SM_RSVD = 2'b11
  } save_method_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_FETCH,
    ARB_DATA,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/unified_mem_arbiter_store_lane_gen.sv
// Store lane generator: byte enables, lane-replicated write data and misalignment flag.
// Combinational; shared with the load-extension unit.
module store_lane_gen
  import unified_mem_arbiter_pkg::*;
(
  input  logic [1:0]  method_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  always_comb begin
    be_o       = '0;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    case (save_method_e'(method_i))
      SM_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SM_HALF: begin
        be_o       = 4'b0011 << {addr_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_i[0];
      end
      SM_WORD: begin
        be_o       = '1;
        misalign_o = (addr_i != 2'b00);
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single-ported unified memory between fetch and load/store,
// sequencing each access through IDLE -> FETCH/DATA -> RESP.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic [N-1:0] if_rdata,
  output logic         if_valid,
  input  logic         dm_req,
  input  logic         dm_we,
  input  logic [N-1:0] dm_addr,
  input  logic [N-1:0] dm_wdata,
  input  logic [1:0]   dm_save_method,
  output logic [N-1:0] dm_rdata,
  output logic         dm_valid,
  output logic         dm_err,
  output logic         stall_if,
  output logic         stall_dm,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [3:0]   mem_be,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready
);

  arb_state_e   state_q, state_d;
  logic [N-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [N-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic [3:0]   be_q, be_d, cnt_q, cnt_d;
  logic         we_q, we_d, resp_dm_q, resp_dm_d, err_q, err_d, last_dm_q, last_dm_d;
  logic [3:0]   lane_be;
  logic [N-1:0] lane_wdata;
  logic         lane_misalign;
  logic         busy;
  logic         unused_if_addr_lsb;

  assign unused_if_addr_lsb = ^if_addr[1:0];

  store_lane_gen u_lane (
    .method_i   (dm_save_method),
    .addr_i     (dm_addr[1:0]),
    .wdata_i    (dm_wdata),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .misalign_o (lane_misalign)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    resp_dm_d  = resp_dm_q;
    err_d      = err_q;
    last_dm_d  = last_dm_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        // Data has priority unless it also won the previous completed grant.
        if (dm_req && (!if_req || !last_dm_q)) begin
          resp_dm_d = 1'b1;
          addr_d    = {dm_addr[N-1:2], 2'b00};
          we_d      = dm_we;
          cnt_d     = '0;
          be_d      = dm_we ? lane_be : '1;
          wdata_d   = dm_we ? lane_wdata : '0;
          if (dm_we && lane_misalign) begin
            err_d     = 1'b1;
            last_dm_d = 1'b1;
            state_d   = ARB_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ARB_DATA;
          end
        end else if (if_req) begin
          resp_dm_d = 1'b0;
          addr_d    = {if_addr[N-1:2], 2'b00};
          we_d      = 1'b0;
          cnt_d     = '0;
          be_d      = '1;
          wdata_d   = '0;
          err_d     = 1'b0;
          state_d   = ARB_FETCH;
        end
      end
      ARB_FETCH, ARB_DATA: begin
        if (mem_ready) begin
          if (state_q == ARB_FETCH) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
          last_dm_d = (state_q == ARB_DATA);
          state_d   = ARB_RESP;
        end else if (cnt_q == 4'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          last_dm_d = (state_q == ARB_DATA);
          state_d   = ARB_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      resp_dm_q  <= 1'b0;
      err_q      <= 1'b0;
      last_dm_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      resp_dm_q  <= resp_dm_d;
      err_q      <= err_d;
      last_dm_q  <= last_dm_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Memory-side outputs are gated so they read as zero outside busy states.
  assign busy      = (state_q == ARB_FETCH) || (state_q == ARB_DATA);
  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_be    = busy ? be_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;

  assign if_valid = (state_q == ARB_RESP) && !resp_dm_q;
  assign dm_valid = (state_q == ARB_RESP) && resp_dm_q;
  assign dm_err   = (state_q == ARB_RESP) && err_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign stall_if = if_req & ~if_valid;
  assign stall_dm = dm_req & ~dm_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a transaction-level reference model
// compared every cycle, plus literal expectations per scenario.
module tb_unified_mem_arbiter;

  localparam int P_IDLE = 0;
  localparam int P_BUSY = 1;
  localparam int P_RESP = 2;
  localparam int TMO    = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [1:0]  dm_save_method = 2'b10;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        if_valid, dm_valid, dm_err, stall_if, stall_dm, mem_req, mem_we;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  unified_mem_arbiter #(.N(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_save_method(dm_save_method), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .dm_err(dm_err), .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: ready after wait_cycles busy cycles; optional stray ready while idle.
  int          wait_cycles = 0;
  int          resp_cnt = 0;
  bit          spurious = 1'b0;
  logic [31:0] last_rdata = '0;

  always @(negedge clk) begin
    if (mem_req) begin
      if (resp_cnt == wait_cycles) begin
        mem_ready  = 1'b1;
        mem_rdata  = $urandom;
        last_rdata = mem_rdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      resp_cnt++;
    end else begin
      mem_ready = spurious;
      mem_rdata = $urandom;
      resp_cnt  = 0;
    end
  end

  // Reference model: transactions described by phase, owner and latched request.
  function automatic logic [3:0] exp_be(input logic [1:0] m, input logic [1:0] a);
    case (m)
      2'd0:    return 4'(1 << a);
      2'd1:    return 4'(3 << (a & 2'b10));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] m, input logic [31:0] w);
    case (m)
      2'd0:    return {24'b0, w[7:0]} * 32'h0101_0101;
      2'd1:    return {16'b0, w[15:0]} * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic bit store_bad(input logic [1:0] m, input logic [1:0] a);
    return (m == 2'd3) || (m == 2'd1 && a[0]) || (m == 2'd2 && a != 2'd0);
  endfunction

  int          m_phase = P_IDLE;
  int          m_busy = 0;
  bit          m_dm = 0, m_err = 0, m_last_dm = 0, m_we = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_dm_rd = '0;
  logic [3:0]  m_be = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_IDLE; m_busy <= 0; m_dm <= 0; m_err <= 0; m_last_dm <= 0; m_we <= 0;
      m_addr <= '0; m_wdata <= '0; m_if_rd <= '0; m_dm_rd <= '0; m_be <= '0;
    end else if (m_phase == P_IDLE) begin
      if (dm_req && (!if_req || !m_last_dm)) begin
        m_dm    <= 1;
        m_we    <= dm_we;
        m_addr  <= dm_addr & 32'hFFFF_FFFC;
        m_busy  <= 0;
        m_be    <= dm_we ? exp_be(dm_save_method, dm_addr[1:0]) : 4'hF;
        m_wdata <= dm_we ? exp_wd(dm_save_method, dm_wdata) : 32'h0;
        if (dm_we && store_bad(dm_save_method, dm_addr[1:0])) begin
          m_phase <= P_RESP; m_err <= 1; m_last_dm <= 1;
        end else begin
          m_phase <= P_BUSY; m_err <= 0;
        end
      end else if (if_req) begin
        m_dm <= 0; m_we <= 0; m_addr <= if_addr & 32'hFFFF_FFFC; m_busy <= 0;
        m_be <= 4'hF; m_wdata <= 32'h0; m_err <= 0; m_phase <= P_BUSY;
      end
    end else if (m_phase == P_BUSY) begin
      if (mem_ready) begin
        if (!m_dm) m_if_rd <= mem_rdata;
        else if (!m_we) m_dm_rd <= mem_rdata;
        m_phase <= P_RESP; m_last_dm <= m_dm;
      end else if (m_busy + 1 == TMO) begin
        m_phase <= P_RESP; m_err <= 1; m_last_dm <= m_dm;
      end else begin
        m_busy <= m_busy + 1;
      end
    end else begin
      m_phase <= P_IDLE;
    end
  end

  always @(negedge clk) begin
    chk("if_valid",  if_valid,  32'(m_phase == P_RESP && !m_dm));
    chk("dm_valid",  dm_valid,  32'(m_phase == P_RESP && m_dm));
    chk("dm_err",    dm_err,    32'(m_phase == P_RESP && m_err));
    chk("mem_req",   mem_req,   32'(m_phase == P_BUSY));
    chk("mem_we",    mem_we,    32'(m_phase == P_BUSY && m_we));
    chk("mem_addr",  mem_addr,  (m_phase == P_BUSY) ? m_addr : 32'h0);
    chk("mem_be",    mem_be,    (m_phase == P_BUSY) ? 32'(m_be) : 32'h0);
    chk("mem_wdata", mem_wdata, (m_phase == P_BUSY) ? m_wdata : 32'h0);
    chk("if_rdata",  if_rdata,  m_if_rd);
    chk("dm_rdata",  dm_rdata,  m_dm_rd);
    chk("stall_if",  stall_if,  32'(if_req && !(m_phase == P_RESP && !m_dm)));
    chk("stall_dm",  stall_dm,  32'(dm_req && !(m_phase == P_RESP && m_dm)));
  end

  // Single-requester access with measurements taken at negedges.
  int          r_lat, r_busy, r_stall;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wd;
  logic        r_we, r_err, r_which;

  task automatic access(input bit is_dm, input bit we, input logic [1:0] meth,
                        input logic [31:0] addr, input logic [31:0] wd, input int waitc);
    wait_cycles = waitc;
    r_lat = -1; r_busy = 0; r_stall = 0; r_be = '0; r_addr = '0; r_wd = '0;
    r_we = 0; r_err = 0; r_which = 0;
    @(posedge clk); #1;
    if (is_dm) begin
      dm_req = 1; dm_we = we; dm_save_method = meth; dm_addr = addr; dm_wdata = wd;
    end else begin
      if_req = 1; if_addr = addr;
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mem_req) begin
        if (r_busy == 0) begin
          r_be = mem_be; r_addr = mem_addr; r_wd = mem_wdata; r_we = mem_we;
        end
        r_busy++;
        // Requester inputs wander after the grant; the latched access must not move.
        dm_addr = $urandom; dm_wdata = $urandom; if_addr = $urandom;
      end
      if (is_dm ? stall_dm : stall_if) r_stall++;
      if (if_valid || dm_valid) begin
        r_lat = n; r_err = dm_err; r_which = dm_valid;
        break;
      end
    end
    chk("access_completed", 32'(r_lat >= 0), 32'd1);
    @(posedge clk); #1;
    if_req = 0; dm_req = 0;
  endtask

  bit          q[$];
  logic [31:0] prev;
  bit          fdone, ddone;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_mem_req",  mem_req,  32'd0);
    chk("reset_mem_be",   mem_be,   32'd0);
    chk("reset_if_rdata", if_rdata, 32'd0);
    chk("reset_dm_rdata", dm_rdata, 32'd0);
    @(posedge clk); #1 rst_n = 1;

    // Both requesters from reset: data first, then fetch.
    q.delete(); fdone = 0; ddone = 0; wait_cycles = 0;
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h0000_0010;
    dm_req = 1; dm_we = 0; dm_save_method = 2'b10; dm_addr = 32'h0000_0300;
    for (int n = 0; n < 30 && !(fdone && ddone); n++) begin
      bit fv, dv;
      @(negedge clk);
      fv = if_valid; dv = dm_valid;
      if (dv) q.push_back(1'b1);
      if (fv) q.push_back(1'b0);
      @(posedge clk); #1;
      if (fv) begin if_req = 0; fdone = 1; end
      if (dv) begin dm_req = 0; ddone = 1; end
    end
    if_req = 0; dm_req = 0;
    chk("pair_count", q.size(), 32'd2);
    if (q.size() == 2) begin
      chk("pair_first_is_data",   32'(q[0]), 32'd1);
      chk("pair_second_is_fetch", 32'(q[1]), 32'd0);
    end

    // Both held continuously: grants alternate at one access per 3 cycles.
    q.delete();
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h0000_0020;
    dm_req = 1; dm_we = 0; dm_addr = 32'h0000_0400;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (dm_valid) q.push_back(1'b1);
      if (if_valid) q.push_back(1'b0);
    end
    @(posedge clk); #1;
    if_req = 0; dm_req = 0;
    chk("alt_count", q.size(), 32'd4);
    foreach (q[i]) chk("alt_order", 32'(q[i]), 32'(i % 2 == 0));

    // Lone fetch with two memory wait cycles.
    access(0, 0, 2'b10, 32'h0000_0104, 32'h0, 2);
    chk("fetch_lat",   r_lat,   32'd4);
    chk("fetch_busy",  r_busy,  32'd3);
    chk("fetch_addr",  r_addr,  32'h0000_0104);
    chk("fetch_be",    r_be,    32'hF);
    chk("fetch_stall", r_stall, 32'd4);
    chk("fetch_which", r_which, 32'd0);
    chk("fetch_rdata", if_rdata, last_rdata);

    // Byte store to 0x203.
    prev = dm_rdata;
    access(1, 1, 2'b00, 32'h0000_0203, 32'h0000_00AB, 0);
    chk("sb_be",    r_be,   32'b1000);
    chk("sb_wdata", r_wd,   32'hABAB_ABAB);
    chk("sb_addr",  r_addr, 32'h0000_0200);
    chk("sb_we",    r_we,   32'd1);
    chk("sb_lat",   r_lat,  32'd2);
    chk("sb_err",   r_err,  32'd0);
    chk("sb_rdata_kept", dm_rdata, prev);

    // Half store to 0x202 with one wait cycle.
    access(1, 1, 2'b01, 32'h0000_0202, 32'h1234_CDEF, 1);
    chk("sh_be",    r_be,  32'b1100);
    chk("sh_wdata", r_wd,  32'hCDEF_CDEF);
    chk("sh_lat",   r_lat, 32'd3);

    // Aligned word store.
    access(1, 1, 2'b10, 32'h0000_0300, 32'hDEAD_BEEF, 0);
    chk("sw_be",    r_be, 32'hF);
    chk("sw_wdata", r_wd, 32'hDEAD_BEEF);

    // Misaligned word store, with a stray mem_ready while idle.
    spurious = 1;
    access(1, 1, 2'b10, 32'h0000_0206, 32'h5555_AAAA, 0);
    spurious = 0;
    chk("misw_lat",  r_lat,  32'd1);
    chk("misw_busy", r_busy, 32'd0);
    chk("misw_err",  r_err,  32'd1);

    // Reserved method.
    access(1, 1, 2'b11, 32'h0000_0200, 32'h1, 0);
    chk("rsvd_lat",  r_lat,  32'd1);
    chk("rsvd_busy", r_busy, 32'd0);
    chk("rsvd_err",  r_err,  32'd1);

    // Unaligned load is served normally from the aligned word.
    access(1, 0, 2'b10, 32'h0000_020A, 32'h0, 0);
    chk("ld_addr",  r_addr,   32'h0000_0208);
    chk("ld_be",    r_be,     32'hF);
    chk("ld_err",   r_err,    32'd0);
    chk("ld_rdata", dm_rdata, last_rdata);

    // Timeout: memory never answers.
    prev = dm_rdata;
    access(1, 0, 2'b10, 32'h0000_0500, 32'h0, 99);
    chk("tmo_busy",  r_busy,   32'd15);
    chk("tmo_lat",   r_lat,    32'd16);
    chk("tmo_err",   r_err,    32'd1);
    chk("tmo_rdata", dm_rdata, prev);

    // Reset in the middle of a data access.
    wait_cycles = 99;
    @(posedge clk); #1;
    dm_req = 1; dm_we = 0; dm_addr = 32'h0000_0100;
    repeat (3) @(negedge clk);
    chk("mid_busy", mem_req, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_imm_mem_req", mem_req, 32'd0);
    chk("rst_imm_valid",   32'(dm_valid | if_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_valid", 32'(dm_valid | if_valid), 32'd0);
    end
    @(posedge clk); #1;
    dm_req = 0; rst_n = 1; wait_cycles = 0;

    access(1, 0, 2'b10, 32'h0000_0040, 32'h0, 0);
    chk("post_rst_lat",   r_lat,    32'd2);
    chk("post_rst_err",   r_err,    32'd0);
    chk("post_rst_rdata", dm_rdata, last_rdata);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
